// File: rtl/lvds_iq_rx.sv
// lvds_iq_rx: receive end of the serial LVDS I/Q link.
// Synchronizes the serial data and forwarded clock into the 64 MHz fabric domain.
// Hunts for a frame start after a run of idle zeros and collects 32-bit frames.
// Each frame is checked, and the block presents I/Q samples, end-of-message and error strobes.
// Optional macro LVDS_IQ_RX_ERRCNT_EN enables the saturating frame-error counter on err_count.
module lvds_iq_rx #(
  parameter int ZERO_RUN       = 16,
  parameter int TIMEOUT_CYCLES = 255,
  parameter bit RX_CLK_POL     = 1'b0
) (
  input  logic        clk64mhz,
  input  logic        reset_n,
  input  logic        rx_a,
  input  logic        rx_clk_a,
  output logic [12:0] i_data,
  output logic [12:0] q_data,
  output logic        sample_valid,
  output logic        msg_end,
  output logic        frame_err,
  output logic        locked,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {HUNT, COLLECT, CHECK} state_t;

  state_t      state_reg, state_next;
  logic        data_s1, data_s2;
  logic        clk_s1, clk_s2, clk_s3;
  logic        edge_det;
  logic [5:0]  zrun_reg, zrun_next;
  logic [31:0] shift_reg, shift_next;
  logic [4:0]  bitcnt_reg, bitcnt_next;
  logic [15:0] idle_reg, idle_next;
  logic [12:0] i_next, q_next;
  logic        sv_next, me_next, fe_next;
  logic        markers_ok;

  // Two-flop synchronizers on data and clock, plus a third clock flop for edge detection
  always_ff @(posedge clk64mhz) begin
    if (!reset_n) begin
      data_s1 <= 1'b0;
      data_s2 <= 1'b0;
      clk_s1  <= 1'b0;
      clk_s2  <= 1'b0;
      clk_s3  <= 1'b0;
    end else begin
      data_s1 <= rx_a;
      data_s2 <= data_s1;
      clk_s1  <= rx_clk_a;
      clk_s2  <= clk_s1;
      clk_s3  <= clk_s2;
    end
  end

  assign edge_det   = RX_CLK_POL ? (~clk_s2 & clk_s3) : (clk_s2 & ~clk_s3);
  assign markers_ok = (shift_reg[31:30] == 2'b10) && (shift_reg[15:14] == 2'b01) && !shift_reg[0];
  assign locked     = (state_reg == COLLECT);

  // State, frame datapath and registered strobes
  always_ff @(posedge clk64mhz) begin
    if (!reset_n) begin
      state_reg    <= HUNT;
      zrun_reg     <= 6'd0;
      shift_reg    <= 32'd0;
      bitcnt_reg   <= 5'd0;
      idle_reg     <= 16'd0;
      i_data       <= 13'd0;
      q_data       <= 13'd0;
      sample_valid <= 1'b0;
      msg_end      <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      zrun_reg     <= zrun_next;
      shift_reg    <= shift_next;
      bitcnt_reg   <= bitcnt_next;
      idle_reg     <= idle_next;
      i_data       <= i_next;
      q_data       <= q_next;
      sample_valid <= sv_next;
      msg_end      <= me_next;
      frame_err    <= fe_next;
    end
  end

  // Next-state logic: frame-start hunt, bit collection with idle timeout, frame check
  always_comb begin
    state_next  = state_reg;
    zrun_next   = zrun_reg;
    shift_next  = shift_reg;
    bitcnt_next = bitcnt_reg;
    idle_next   = idle_reg;
    i_next      = i_data;
    q_next      = q_data;
    sv_next     = 1'b0;
    me_next     = 1'b0;
    fe_next     = 1'b0;
    case (state_reg)
      HUNT: begin
        if (edge_det) begin
          if (!data_s2) begin
            if (zrun_reg != 6'd63) zrun_next = zrun_reg + 6'd1;
          end else if (int'(zrun_reg) >= ZERO_RUN) begin
            // This 1 is frame bit 31 (start marker)
            shift_next  = {31'd0, data_s2};
            bitcnt_next = 5'd30;
            idle_next   = 16'd0;
            state_next  = COLLECT;
          end else begin
            zrun_next = 6'd0;
          end
        end
      end
      COLLECT: begin
        if (edge_det) begin
          shift_next = {shift_reg[30:0], data_s2};
          idle_next  = 16'd0;
          if (bitcnt_reg == 5'd0) state_next = CHECK;
          else bitcnt_next = bitcnt_reg - 5'd1;
        end else if (idle_reg == 16'(TIMEOUT_CYCLES - 1)) begin
          // Serial clock stalled mid-frame: abandon it
          fe_next    = 1'b1;
          zrun_next  = 6'd0;
          state_next = HUNT;
        end else begin
          idle_next = idle_reg + 16'd1;
        end
      end
      CHECK: begin
        if (markers_ok && shift_reg[16]) begin
          i_next  = shift_reg[29:17];
          q_next  = shift_reg[13:1];
          sv_next = 1'b1;
        end else if (markers_ok && shift_reg[29:17] == 13'd0 && shift_reg[13:1] == 13'd0) begin
          me_next = 1'b1;
        end else begin
          fe_next = 1'b1;
        end
        // A serial edge landing here is treated as the first hunt bit
        zrun_next  = (edge_det && !data_s2) ? 6'd1 : 6'd0;
        state_next = HUNT;
      end
      default: state_next = HUNT;
    endcase
  end

`ifdef LVDS_IQ_RX_ERRCNT_EN
  // Saturating count of frame errors, cleared only by reset
  always_ff @(posedge clk64mhz) begin
    if (!reset_n) err_count <= 8'd0;
    else if (fe_next && err_count != 8'hFF) err_count <= err_count + 8'd1;
  end
`else
  assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_lvds_iq_rx.sv
// tb_lvds_iq_rx: directed bench for lvds_iq_rx with a strobe scoreboard.
// Serial link driven at 8 MHz (8 fabric cycles per bit); expected strobes are queued with their cycle.
`timescale 1ns/1ps
module tb_lvds_iq_rx;

  logic        clk64mhz = 1'b0;
  logic        reset_n;
  logic        rx_a;
  logic        rx_clk_a;
  logic [12:0] i_data, q_data;
  logic        sample_valid, msg_end, frame_err, locked;
  logic [7:0]  err_count;

  typedef struct {
    int          kind;   // 1 data, 2 end-of-message, 3 error
    logic [12:0] i;
    logic [12:0] q;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          err_inc;
  int          exp_err = 0;
  logic [12:0] mi = 13'd0;
  logic [12:0] mq = 13'd0;

  lvds_iq_rx dut (
    .clk64mhz(clk64mhz), .reset_n(reset_n), .rx_a(rx_a), .rx_clk_a(rx_clk_a),
    .i_data(i_data), .q_data(q_data), .sample_valid(sample_valid), .msg_end(msg_end),
    .frame_err(frame_err), .locked(locked), .err_count(err_count)
  );

  always #8 clk64mhz = ~clk64mhz;
  always @(posedge clk64mhz) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk64mhz);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [12:0] i, input logic [12:0] q);
    return {2'b10, i, 1'b1, 2'b01, q, 1'b0};
  endfunction

  // Send the top n bits of w MSB first; on the last bit's rising edge queue an expected strobe
  task automatic send_bits(input logic [31:0] w, input int n, input int kind, input int lat);
    for (int b = 31; b > 31 - n; b--) begin
      rx_a = w[b];
      rx_clk_a = 1'b0;
      tick(4);
      rx_clk_a = 1'b1;
      if (b == 32 - n && kind != 0) sbq.push_back('{kind, mi, mq, cyc + lat});
      tick(4);
    end
  endtask

  task automatic send_frame(input logic [12:0] i, input logic [12:0] q);
    mi = i;
    mq = q;
    send_bits(mk(i, q), 32, 1, 4);
    $display("tx frame I=%h Q=%h", i, q);
  endtask

  // Scoreboard monitor: every strobe must match the head of the expected queue
  always @(negedge clk64mhz) begin
    if (reset_n && (sample_valid || msg_end || frame_err)) begin
      exp_t e;
      int   k;
      k = sample_valid ? 1 : (msg_end ? 2 : 3);
      chk("strobe_onehot", 32'(int'(sample_valid) + int'(msg_end) + int'(frame_err)), 32'd1);
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe act=kind%0d exp=none cyc=%0d", k, cyc);
      end else begin
        e = sbq.pop_front();
        chk("strobe_kind", 32'(k), 32'(e.kind));
        chk("strobe_cycle", 32'(cyc), 32'(e.cyc));
        chk("i_data", {19'd0, i_data}, {19'd0, e.i});
        chk("q_data", {19'd0, q_data}, {19'd0, e.q});
        $display("rx strobe kind=%0d I=%h Q=%h cyc=%0d", k, i_data, q_data, cyc);
      end
    end
  end

  initial begin
`ifdef LVDS_IQ_RX_ERRCNT_EN
    err_inc = 1;
`else
    err_inc = 0;
`endif
    reset_n  = 1'b0;
    rx_a     = 1'b0;
    rx_clk_a = 1'b0;
    tick(3);
    chk("reset_i", {19'd0, i_data}, 32'd0);
    chk("reset_q", {19'd0, q_data}, 32'd0);
    chk("reset_strobes", {29'd0, sample_valid, msg_end, frame_err}, 32'd0);
    chk("reset_locked", {31'd0, locked}, 32'd0);
    chk("reset_errcnt", {24'd0, err_count}, 32'd0);
    reset_n = 1'b1;
    tick(2);

    // Basic frame after 64 idle zeros
    send_bits(32'd0, 32, 0, 0);
    send_bits(32'd0, 32, 0, 0);
    send_frame(13'h0123, 13'h1ABC);
    tick(4);
    chk("frame1_i", {19'd0, i_data}, 32'h0123);
    chk("frame1_q", {19'd0, q_data}, 32'h1ABC);

    // Three data frames with idle words, then end-of-message
    send_bits(32'd0, 32, 0, 0);
    send_frame(13'h0001, 13'h1FFF);
    send_bits(32'd0, 32, 0, 0);
    send_frame(13'h1555, 13'h0AAA);
    send_bits(32'd0, 32, 0, 0);
    send_frame(13'h0FED, 13'h0321);
    send_bits(32'd0, 32, 0, 0);
    send_bits(32'h8000_4000, 32, 2, 4);
    $display("tx end-of-message");
    tick(4);
    chk("eom_hold_i", {19'd0, i_data}, 32'h0FED);
    chk("eom_hold_q", {19'd0, q_data}, 32'h0321);

    // Bad middle marker
    send_bits(32'd0, 32, 0, 0);
    send_bits(mk(13'h0AAA, 13'h0555) | 32'h0000_C000, 32, 3, 4);
    $display("tx bad-marker frame");
    exp_err = exp_err + err_inc;
    tick(4);
    chk("errcnt_marker", {24'd0, err_count}, 32'(exp_err));
    send_bits(32'd0, 32, 0, 0);
    send_frame(13'h0042, 13'h0F0F);

    // Zero run too short: no lock
    send_bits(32'd0, 8, 0, 0);
    send_bits(32'h8000_0000, 1, 0, 0);
    chk("short_run_nolock", {31'd0, locked}, 32'd0);
    send_bits(32'd0, 16, 0, 0);
    send_frame(13'h1234, 13'h0765);

    // Serial clock stops after bit 20
    send_bits(32'd0, 32, 0, 0);
    send_bits(mk(13'h1FFF, 13'h0001), 12, 3, 258);
    chk("timeout_locked_mid", {31'd0, locked}, 32'd1);
    rx_a = 1'b0;
    tick(270);
    chk("timeout_locked_drop", {31'd0, locked}, 32'd0);
    exp_err = exp_err + err_inc;
    chk("errcnt_timeout", {24'd0, err_count}, 32'(exp_err));
    $display("tx timeout case done");
    send_bits(32'd0, 32, 0, 0);
    send_frame(13'h0ABC, 13'h1DEF);

    // Reset mid-frame
    send_bits(32'd0, 32, 0, 0);
    send_bits(mk(13'h0777, 13'h0888), 10, 0, 0);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    chk("midrst_i", {19'd0, i_data}, 32'd0);
    chk("midrst_q", {19'd0, q_data}, 32'd0);
    chk("midrst_locked", {31'd0, locked}, 32'd0);
    chk("midrst_errcnt", {24'd0, err_count}, 32'd0);
    $display("tx mid-frame reset");
    mi = 13'd0;
    mq = 13'd0;
    exp_err = 0;
    send_bits(32'd0, 32, 0, 0);
    send_frame(13'h1357, 13'h0246);

    tick(20);
    chk("queue_drained", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
